// File: rtl/branch_predict_unit_if.sv
// Bus between the fetch/execute pipeline stages and the branch predictor.
// The master side is the pipeline (drives IF/EX info), the slave side is the predictor.
interface branch_predict_unit_if #(
  parameter int PC_W = 16
);
  // IF-stage prediction request and response
  logic [PC_W-1:0] if_pc;
  logic [4:0]      if_op;
  logic [PC_W-1:0] if_target;
  logic            pred_taken;
  logic [PC_W-1:0] pred_pc;
  // EX-stage resolution
  logic            ex_valid;
  logic [4:0]      ex_op;
  logic [PC_W-1:0] ex_pc;
  logic            ex_pred_taken;
  logic            ex_taken;
  logic [PC_W-1:0] ex_target;
  // Recovery outputs
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;

  modport master (
    output if_pc, if_op, if_target,
    output ex_valid, ex_op, ex_pc, ex_pred_taken, ex_taken, ex_target,
    input  pred_taken, pred_pc, redirect, redirect_pc, flush
  );

  modport slave (
    input  if_pc, if_op, if_target,
    input  ex_valid, ex_op, ex_pc, ex_pred_taken, ex_taken, ex_target,
    output pred_taken, pred_pc, redirect, redirect_pc, flush
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor (2-bit saturating counters indexed by pc[IDX_W:1])
// with a one-cycle registered redirect/flush on mispredict.
// Optional macro BP_BYPASS_EN: when an IF lookup hits the entry being updated
// in the same cycle, the prediction uses the post-update counter value.
module branch_predict_unit #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_predict_unit_if.slave bus
);
  localparam int              TBL_N  = 1 << IDX_W;
  localparam logic [PC_W-1:0] PC_INC = PC_W'(2);

  typedef enum logic {IDLE, RECOVER} state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q [TBL_N];
  logic            redirect_q, redirect_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [1:0]       if_cnt, upd_cnt;
  logic             res, mis;
  logic [PC_W-1:0]  correct_pc;

  // Conditional branches occupy opcodes 01100..01111.
  function automatic logic is_branch(input logic [4:0] op);
    return op[4:2] == 3'b011;
  endfunction

  // Saturating 2-bit counter step: up on taken, down on not-taken.
  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    if (taken) r = (c == 2'b11) ? 2'b11 : c + 2'b01;
    else       r = (c == 2'b00) ? 2'b00 : c - 2'b01;
    return r;
  endfunction

  assign if_idx = bus.if_pc[IDX_W:1];
  assign ex_idx = bus.ex_pc[IDX_W:1];

  // Resolve/mispredict qualification; the RECOVER cycle holds a wrong-path instruction.
  always_comb begin
    res        = bus.ex_valid && is_branch(bus.ex_op) && (state_q == IDLE);
    mis        = res && (bus.ex_pred_taken != bus.ex_taken);
    upd_cnt    = sat_update(cnt_q[ex_idx], bus.ex_taken);
    correct_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + PC_INC;
  end

  // IF-stage prediction, purely combinational.
  always_comb begin
`ifdef BP_BYPASS_EN
    if_cnt = (res && (if_idx == ex_idx)) ? upd_cnt : cnt_q[if_idx];
`else
    if_cnt = cnt_q[if_idx];
`endif
    bus.pred_taken = is_branch(bus.if_op) && if_cnt[1];
    bus.pred_pc    = bus.pred_taken ? bus.if_target : bus.if_pc + PC_INC;
  end

  // Counter table: reset to weakly not-taken, update on every resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_N; i++) cnt_q[i] <= 2'b01;
    end else if (res) begin
      cnt_q[ex_idx] <= upd_cnt;
    end
  end

  // Recovery FSM next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    unique case (state_q)
      IDLE: begin
        if (mis) begin
          state_d       = RECOVER;
          redirect_d    = 1'b1;
          redirect_pc_d = correct_pc;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and redirect output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.redirect    = redirect_q;
  assign bus.flush       = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: table-driven counter/redirect
// sequence plus hand-written reset, recovery, wrap and collision cases.
module tb_branch_predict_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  branch_predict_unit_if #(.PC_W(16)) bp_bus ();

  branch_predict_unit #(.IDX_W(4), .PC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bp_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic        taken;
    logic        pt;
    logic        exp_redir;
    logic [15:0] exp_rpc;
    logic        exp_pt;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_if(input logic [15:0] pc, input logic [4:0] op, input logic [15:0] tgt);
    bp_bus.if_pc     = pc;
    bp_bus.if_op     = op;
    bp_bus.if_target = tgt;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] op, input logic [15:0] pc,
                        input logic pt, input logic t, input logic [15:0] tgt);
    bp_bus.ex_valid      = v;
    bp_bus.ex_op         = op;
    bp_bus.ex_pc         = pc;
    bp_bus.ex_pred_taken = pt;
    bp_bus.ex_taken      = t;
    bp_bus.ex_target     = tgt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_ex(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_if(16'h0000, 5'b00000, 16'h0000);
    set_ex(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 16'h0000);

    //            op        tk  pt  redir rpc       pred after
    vecs[0]  = '{5'b01100, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b1};
    vecs[1]  = '{5'b01101, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[2]  = '{5'b01110, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[3]  = '{5'b01111, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[4]  = '{5'b01100, 1'b0, 1'b1, 1'b1, 16'h0012, 1'b1};
    vecs[5]  = '{5'b01101, 1'b0, 1'b1, 1'b1, 16'h0012, 1'b0};
    vecs[6]  = '{5'b01110, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[7]  = '{5'b01111, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[8]  = '{5'b01100, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[9]  = '{5'b01101, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b0};
    vecs[10] = '{5'b01110, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b1};
    vecs[11] = '{5'b10000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[12] = '{5'b01011, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};

    // Reset state
    #12;
    chk("reset_redirect", {31'd0, bp_bus.redirect}, 32'd0);
    chk("reset_flush", {31'd0, bp_bus.flush}, 32'd0);
    chk("reset_redirect_pc", {16'd0, bp_bus.redirect_pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Initial prediction and all-counters-weak-NT probe
    set_if(16'h0010, 5'b01100, 16'h0040);
    #1;
    chk("init_pred_taken", {31'd0, bp_bus.pred_taken}, 32'd0);
    chk("init_pred_pc", {16'd0, bp_bus.pred_pc}, 32'h0012);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] pc;
      pc = 16'(i * 2);
      set_if(pc, 5'b01111, 16'h0040);
      #1;
      chk($sformatf("init_cnt%0d", i), {31'd0, bp_bus.pred_taken}, 32'd0);
    end

    // Non-branch IF op with PC wrap
    set_if(16'hFFFE, 5'b00001, 16'h1234);
    #1;
    chk("nonbr_pred_taken", {31'd0, bp_bus.pred_taken}, 32'd0);
    chk("nonbr_pred_pc_wrap", {16'd0, bp_bus.pred_pc}, 32'h0000);

    // Table-driven resolve sequence on index 8
    set_if(16'h0010, 5'b01100, 16'h0040);
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      set_ex(1'b1, vecs[v].op, 16'h0010, vecs[v].pt, vecs[v].taken, 16'h0040);
      tick();
      set_ex(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 16'h0000);
      #1;
      chk($sformatf("v%0d_redirect", v), {31'd0, bp_bus.redirect}, {31'd0, vecs[v].exp_redir});
      chk($sformatf("v%0d_flush", v), {31'd0, bp_bus.flush}, {31'd0, vecs[v].exp_redir});
      chk($sformatf("v%0d_redirect_pc", v), {16'd0, bp_bus.redirect_pc}, {16'd0, vecs[v].exp_rpc});
      chk($sformatf("v%0d_pred_taken", v), {31'd0, bp_bus.pred_taken}, {31'd0, vecs[v].exp_pt});
      chk($sformatf("v%0d_pred_pc", v), {16'd0, bp_bus.pred_pc},
          vecs[v].exp_pt ? 32'h0040 : 32'h0012);
      tick();
      chk($sformatf("v%0d_pulse_end", v), {31'd0, bp_bus.redirect}, 32'd0);
    end

    // Branch in the RECOVER cycle is ignored
    do_reset();
    @(negedge clk);
    set_ex(1'b1, 5'b01100, 16'h0010, 1'b0, 1'b1, 16'h0040);
    tick();
    set_ex(1'b1, 5'b01100, 16'h0020, 1'b0, 1'b1, 16'h0080);
    chk("rec_redirect", {31'd0, bp_bus.redirect}, 32'd1);
    chk("rec_redirect_pc", {16'd0, bp_bus.redirect_pc}, 32'h0040);
    tick();
    set_ex(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    set_if(16'h0020, 5'b01100, 16'h0080);
    #1;
    chk("rec_no_second_redirect", {31'd0, bp_bus.redirect}, 32'd0);
    chk("rec_no_second_flush", {31'd0, bp_bus.flush}, 32'd0);
    chk("rec_no_cnt_update", {31'd0, bp_bus.pred_taken}, 32'd0);

    // Not-taken mispredict at the top of the address space wraps
    @(negedge clk);
    set_ex(1'b1, 5'b01111, 16'hFFFE, 1'b1, 1'b0, 16'h1234);
    tick();
    set_ex(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("wrap_redirect", {31'd0, bp_bus.redirect}, 32'd1);
    chk("wrap_redirect_pc", {16'd0, bp_bus.redirect_pc}, 32'h0000);
    tick();

    // Asynchronous reset during RECOVER
    set_if(16'h0010, 5'b01100, 16'h0040);
    @(negedge clk);
    set_ex(1'b1, 5'b01100, 16'h0010, 1'b0, 1'b1, 16'h0040);
    tick();
    set_ex(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("arst_pre_redirect", {31'd0, bp_bus.redirect}, 32'd1);
    chk("arst_pre_cnt", {31'd0, bp_bus.pred_taken}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_redirect", {31'd0, bp_bus.redirect}, 32'd0);
    chk("arst_flush", {31'd0, bp_bus.flush}, 32'd0);
    chk("arst_redirect_pc", {16'd0, bp_bus.redirect_pc}, 32'h0000);
    chk("arst_cnt", {31'd0, bp_bus.pred_taken}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Same-index IF/EX collision
    @(negedge clk);
    set_if(16'h0010, 5'b01100, 16'h0040);
    set_ex(1'b1, 5'b01100, 16'h0010, 1'b0, 1'b1, 16'h0040);
    #1;
`ifdef BP_BYPASS_EN
    chk("collide_pred_taken", {31'd0, bp_bus.pred_taken}, 32'd1);
`else
    chk("collide_pred_taken", {31'd0, bp_bus.pred_taken}, 32'd0);
`endif
    tick();
    set_ex(1'b0, 5'b00000, 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("collide_after", {31'd0, bp_bus.pred_taken}, 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
